td2box_seq: RTL and testbench



---
 rtl/td2box_seq.sv | 114 +++++++++++
 tb/tb_td2box_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/td2box_seq.sv
// Sequential AES decryption T-table engine: Td2[in] via an iterative GF(2^8) inversion.
// Optional `sbox` output (raw inverse S-box byte) is enabled by defining TD2BOX_SBOX_OUT_EN.
module td2box_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready
`ifdef TD2BOX_SBOX_OUT_EN
  ,
  output logic [7:0]  sbox
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_INV, S_MIX, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  sq_q, acc_q;
  logic [2:0]  cnt_q;
  logic [31:0] out_q;
  logic        out_valid_q;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xt(s);
    end
    return p;
  endfunction

  logic [7:0]  inv_aff, sq2, acc_nx;
  logic [7:0]  x2, x4, x8;
  logic [31:0] packed_w;

  assign inv_aff = {in[6:0], in[7]} ^ {in[4:0], in[7:5]} ^ {in[1:0], in[7:2]} ^ 8'h05;
  assign sq2     = gmul(sq_q, sq_q);
  assign acc_nx  = gmul(acc_q, sq2);

  // After seven iterations acc holds a^254, i.e. the inverse S-box byte.
  assign x2 = xt(acc_q);
  assign x4 = xt(x2);
  assign x8 = xt(x4);
  assign packed_w = {x8 ^ x4 ^ acc_q, x8 ^ x2 ^ acc_q, x8 ^ x4 ^ x2, x8 ^ acc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid)    state_d = S_INV;
      S_INV:  if (cnt_q == 3'd6) state_d = S_MIX;
      S_MIX:                   state_d = S_DONE;
      S_DONE: if (out_ready)   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q        <= 8'h00;
      acc_q       <= 8'h00;
      cnt_q       <= 3'd0;
      out_q       <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          sq_q  <= inv_aff;
          acc_q <= 8'h01;
          cnt_q <= 3'd0;
        end
        S_INV: begin
          sq_q  <= sq2;
          acc_q <= acc_nx;
          cnt_q <= (cnt_q == 3'd6) ? 3'd0 : cnt_q + 3'd1;
        end
        S_MIX: begin
          out_q       <= packed_w;
          out_valid_q <= 1'b1;
        end
        S_DONE: if (out_ready) out_valid_q <= 1'b0;
      endcase
    end
  end

`ifdef TD2BOX_SBOX_OUT_EN
  logic [7:0] sbox_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sbox_q <= 8'h00;
    else if (state_q == S_MIX)  sbox_q <= acc_q;
  end
  assign sbox = sbox_q;
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_td2box_seq.sv
// Self-checking bench for td2box_seq: directed literals, reset, backpressure and a full 256-input sweep.
module tb_td2box_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] dout;
`ifdef TD2BOX_SBOX_OUT_EN
  logic [7:0]  sbox;
`endif

  td2box_seq dut (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .out(dout), .out_valid(out_valid), .out_ready(out_ready)
`ifdef TD2BOX_SBOX_OUT_EN
    , .sbox(sbox)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [7:0]  exp_in = 8'h00;
  bit          have_exp = 1'b0;
  logic [31:0] last_out;
  logic [7:0]  last_sbox;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain polynomial product, then long-division reduction by 0x11B.
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h11B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl_ref(input logic [7:0] x, input int n);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[(i + n) % 8] = x[i];
    return r;
  endfunction

  // Inverse found by exhaustive search rather than exponentiation.
  function automatic logic [7:0] sd_ref(input logic [7:0] b);
    logic [7:0] a, r;
    a = rotl_ref(b, 1) ^ rotl_ref(b, 3) ^ rotl_ref(b, 6) ^ 8'h05;
    r = 8'h00;
    for (int v = 1; v < 256; v++) if (gmul_ref(a, 8'(v)) == 8'h01) r = 8'(v);
    return r;
  endfunction

  function automatic logic [31:0] td2_ref(input logic [7:0] b);
    logic [7:0] s;
    s = sd_ref(b);
    return {gmul_ref(8'h0D, s), gmul_ref(8'h0B, s), gmul_ref(8'h0E, s), gmul_ref(8'h09, s)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && have_exp && out_valid) begin
      chk("out_vs_model", dout, td2_ref(exp_in));
`ifdef TD2BOX_SBOX_OUT_EN
      chk("sbox_vs_model", {24'h0, sbox}, {24'h0, sd_ref(exp_in)});
`endif
    end
  end

  // mode 0: out_ready held high; mode 1: random out_ready
  task automatic run_one(input logic [7:0] b, input int mode);
    int  n;
    bit  r;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("idle_wait", {31'h0, in_ready}, 32'h1);
    din = b; in_valid = 1'b1; exp_in = b; have_exp = 1'b1;
    if (mode == 0) out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; din = 8'($urandom);
    n = 0;
    while (!out_valid && n < 30) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 8);
    last_out = dout;
`ifdef TD2BOX_SBOX_OUT_EN
    last_sbox = sbox;
`endif
    n = 0;
    r = 1'b0;
    while (!r && n < 40) begin
      if (mode == 1) out_ready = (n >= 16) ? 1'b1 : 1'($urandom_range(0, 1));
      r = out_ready;
      @(posedge clk); #1; n++;
    end
    chk("handshake_valid_low", {31'h0, out_valid}, 32'h0);
    chk("handshake_ready_high", {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [31:0] v;
    int          n;
    last_sbox = 8'h00;

    #3 rst_n = 1'b0;
    #4;
    chk("rst_out", dout, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef TD2BOX_SBOX_OUT_EN
    chk("rst_sbox", {24'h0, sbox}, 32'h0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed literals; out_ready held high so the next accept lands at the peak rate.
    run_one(8'h00, 0);
    chk("lit_00", last_out, 32'hA75051F4);
`ifdef TD2BOX_SBOX_OUT_EN
    chk("lit_sbox_00", {24'h0, last_sbox}, 32'h52);
`endif
    run_one(8'h01, 0);
    chk("lit_01", last_out, 32'h65537E41);
    run_one(8'h09, 0);
    chk("lit_09", last_out, 32'h6DF6AD76);
`ifdef TD2BOX_SBOX_OUT_EN
    chk("lit_sbox_09", {24'h0, last_sbox}, 32'h40);
`endif
    run_one(8'h63, 0);
    chk("lit_63", last_out, 32'h00000000);
    run_one(8'h52, 0);
    chk("lit_52", last_out, 32'h05AEDD3E);
    out_ready = 1'b0;

    // Reset in the middle of INV.
    din = 8'h52; in_valid = 1'b1; exp_in = 8'h52;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; have_exp = 1'b0;
    #2;
    chk("midrst_out", dout, 32'h0);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("midrst_no_valid", {31'h0, seen}, 32'h0);

    // Backpressure: DONE must hold and ignore input traffic.
    din = 8'h09; in_valid = 1'b1; exp_in = 8'h09; have_exp = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, 8);
    v = dout;
    chk("bp_value", v, 32'h6DF6AD76);
    for (int i = 0; i < 20; i++) begin
      din = 8'($urandom); in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("bp_out_stable", dout, v);
      chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
      chk("bp_valid_held", {31'h0, out_valid}, 32'h1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", {31'h0, out_valid}, 32'h0);
    chk("bp_release_ready", {31'h0, in_ready}, 32'h1);
    chk("bp_out_kept", dout, v);
    @(posedge clk); #1;
    chk("bp_no_stray_accept", {31'h0, in_ready}, 32'h1);

    // Full sweep with random backpressure.
    for (int i = 0; i < 256; i++) run_one(8'(i), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
